// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for a 5-stage in-order pipeline.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   id_rs1_addr_i, id_rs2_addr_i   source registers of the instruction in ID
//   id_rs1_used_i, id_rs2_used_i   ID instruction actually reads rs1 / rs2
//   ex_rd_addr_i, ex_rd_wren_i     destination and write enable of the EX instruction
//   ex_is_load_i                   EX instruction is a load
//   ex_mispredict_i                branch resolved in EX disagrees with prediction
//   dmem_req_i, dmem_ack_i         MEM-stage data access request / completion
//   pc_en_o .. exmem_en_o          load enables for PC, IF/ID, ID/EX, EX/MEM
//   ifid_flush_o, idex_flush_o     synchronous clear of IF/ID, ID/EX on next edge
//   stall_cnt_o, flush_cnt_o       saturating performance counters
module pipeline_ctrl (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic        id_rs1_used_i,
   input  logic        id_rs2_used_i,
   input  logic [4:0]  ex_rd_addr_i,
   input  logic        ex_rd_wren_i,
   input  logic        ex_is_load_i,
   input  logic        ex_mispredict_i,
   input  logic        dmem_req_i,
   input  logic        dmem_ack_i,
   output logic        pc_en_o,
   output logic        ifid_en_o,
   output logic        idex_en_o,
   output logic        exmem_en_o,
   output logic        ifid_flush_o,
   output logic        idex_flush_o,
   output logic [15:0] stall_cnt_o,
   output logic [15:0] flush_cnt_o
);

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   state_e state;
   logic   rs1_hit;
   logic   rs2_hit;
   logic   load_use;
   logic   mem_stall;
   logic   run_rules;

   assign rs1_hit   = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_hit   = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
   assign load_use  = ex_is_load_i & ex_rd_wren_i & (ex_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit);
   assign mem_stall = dmem_req_i & ~dmem_ack_i;

   // The ack cycle of a memory wait behaves like an ordinary RUN cycle.
   assign run_rules = rst_ni & (((state == StRun) & ~mem_stall) |
                                ((state == StMemWait) & dmem_ack_i));

   always_comb begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_en_o    = 1'b0;
      exmem_en_o   = 1'b0;
      ifid_flush_o = 1'b0;
      idex_flush_o = 1'b0;
      if (run_rules) begin
         if (ex_mispredict_i) begin
            // PC loads the corrected target, wrong-path IF/ID and ID/EX squashed.
            pc_en_o      = 1'b1;
            ifid_en_o    = 1'b1;
            idex_en_o    = 1'b1;
            exmem_en_o   = 1'b1;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID, let the load advance, drop one bubble into EX.
            idex_en_o    = 1'b1;
            exmem_en_o   = 1'b1;
            idex_flush_o = 1'b1;
         end else begin
            pc_en_o      = 1'b1;
            ifid_en_o    = 1'b1;
            idex_en_o    = 1'b1;
            exmem_en_o   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= StRun;
         stall_cnt_o <= 16'd0;
         flush_cnt_o <= 16'd0;
      end else begin
         unique case (state)
            StRun:     if (mem_stall)  state <= StMemWait;
            StMemWait: if (dmem_ack_i) state <= StRun;
            default:                   state <= StRun;
         endcase
         if (!pc_en_o && (stall_cnt_o != 16'hFFFF)) stall_cnt_o <= stall_cnt_o + 16'd1;
         if (ifid_flush_o && (flush_cnt_o != 16'hFFFF)) flush_cnt_o <= flush_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst_ni;
   logic [4:0]  rs1, rs2, rd;
   logic        u1, u2, wren, ld, mis, req, ack;
   logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
   logic [15:0] stall_cnt, flush_cnt;

   pipeline_ctrl dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .id_rs1_addr_i   (rs1),
      .id_rs2_addr_i   (rs2),
      .id_rs1_used_i   (u1),
      .id_rs2_used_i   (u2),
      .ex_rd_addr_i    (rd),
      .ex_rd_wren_i    (wren),
      .ex_is_load_i    (ld),
      .ex_mispredict_i (mis),
      .dmem_req_i      (req),
      .dmem_ack_i      (ack),
      .pc_en_o         (pc_en),
      .ifid_en_o       (ifid_en),
      .idex_en_o       (idex_en),
      .exmem_en_o      (exmem_en),
      .ifid_flush_o    (ifid_flush),
      .idex_flush_o    (idex_flush),
      .stall_cnt_o     (stall_cnt),
      .flush_cnt_o     (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector order: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
   localparam logic [5:0] OutRun   = 6'b111100;
   localparam logic [5:0] OutMis   = 6'b111111;
   localparam logic [5:0] OutLu    = 6'b001101;
   localparam logic [5:0] OutStall = 6'b000000;
   localparam logic [5:0] MaskAll  = 6'b111111;
   localparam logic [5:0] MaskLu   = 6'b110111; // idex_en is moot when ID/EX is flushed

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       wren;
      logic       ld;
      logic       mis;
      logic       req;
      logic       ack;
      logic [5:0] exp;
      logic [5:0] mask;
   } vec_t;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [15:0] exp_stall = 16'd0;
   logic [15:0] exp_flush = 16'd0;
   vec_t        vecs[12];
   vec_t        v;
   logic [15:0] base;

   function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic f1,
                               input logic f2, input logic [4:0] d, input logic we,
                               input logic isld, input logic mp, input logic rq,
                               input logic ak, input logic [5:0] e, input logic [5:0] m);
      vec_t r;
      r.rs1 = a1; r.rs2 = a2; r.u1 = f1; r.u2 = f2; r.rd = d; r.wren = we;
      r.ld = isld; r.mis = mp; r.req = rq; r.ack = ak; r.exp = e; r.mask = m;
      return r;
   endfunction

   task automatic apply(input vec_t x);
      rs1 = x.rs1; rs2 = x.rs2; u1 = x.u1; u2 = x.u2; rd = x.rd; wren = x.wren;
      ld = x.ld; mis = x.mis; req = x.req; ack = x.ack;
   endtask

   task automatic chk_out(input string name, input logic [5:0] e, input logic [5:0] m);
      logic [5:0] act;
      act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};
      tests++;
      if ((act & m) !== (e & m)) begin
         fails++;
         $display("FAIL %s: outputs got %b expected %b (mask %b)", name, act, e, m);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] e);
      tests++;
      if (act !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, e);
      end
   endtask

   // Advance one edge, update the counter model from the expected outputs, check counters.
   task automatic step(input string name, input logic [5:0] e);
      @(posedge clk);
      if (!e[5] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (e[1] && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
      #1;
      chk16({name, "_stall_cnt"}, stall_cnt, exp_stall);
      chk16({name, "_flush_cnt"}, flush_cnt, exp_flush);
      @(negedge clk);
   endtask

   initial begin
      //            rs1 rs2 u1 u2 rd wr ld mis rq ak exp      mask
      vecs[0]  = mk(5'd3, 5'd4, 1, 1, 5'd9, 1, 0, 0, 0, 0, OutRun, MaskAll); // idle ALU op
      vecs[1]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, OutLu,  MaskLu);  // load-use rs1
      vecs[2]  = mk(5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 0, OutRun, MaskAll); // x0 never hazards
      vecs[3]  = mk(5'd1, 5'd7, 0, 1, 5'd7, 1, 1, 0, 0, 0, OutLu,  MaskLu);  // load-use rs2
      vecs[4]  = mk(5'd5, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0, OutRun, MaskAll); // rs1 not read
      vecs[5]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0, OutRun, MaskAll); // not a load
      vecs[6]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 0, 1, 0, 0, 0, OutRun, MaskAll); // no writeback
      vecs[7]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 0, OutMis, MaskAll); // mis beats load-use
      vecs[8]  = mk(5'd2, 5'd3, 1, 1, 5'd9, 1, 0, 1, 0, 0, OutMis, MaskAll); // mispredict alone
      vecs[9]  = mk(5'd2, 5'd3, 1, 1, 5'd9, 1, 0, 0, 1, 1, OutRun, MaskAll); // req+ack no stall
      vecs[10] = mk(5'd8, 5'd3, 1, 1, 5'd8, 1, 1, 0, 1, 1, OutLu,  MaskLu);  // req+ack, load-use
      vecs[11] = mk(5'd2, 5'd3, 1, 1, 5'd9, 1, 0, 1, 1, 1, OutMis, MaskAll); // req+ack, mispredict

      // Reset: outputs and counters forced to zero even with events pending.
      rst_ni = 1'b0;
      v = '0;
      v.mis = 1'b1;
      apply(v);
      #3;
      chk_out("reset_outputs", OutStall, MaskAll);
      chk16("reset_stall_cnt", stall_cnt, 16'd0);
      chk16("reset_flush_cnt", flush_cnt, 16'd0);
      @(posedge clk);
      #1;
      chk16("reset_edge_stall_cnt", stall_cnt, 16'd0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Combinational rules in RUN, one vector per cycle.
      for (int i = 0; i < 12; i++) begin
         apply(vecs[i]);
         #1;
         chk_out($sformatf("vec%0d", i), vecs[i].exp, vecs[i].mask);
         step($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Memory wait, ack three cycles after the request.
      base = exp_stall;
      v = '0;
      v.req = 1'b1;
      apply(v); #1; chk_out("mw_c0", OutStall, MaskAll); step("mw_c0", OutStall);
      apply(v); #1; chk_out("mw_c1", OutStall, MaskAll); step("mw_c1", OutStall);
      v.req = 1'b0; // only MEM_WAIT can still be stalling here
      apply(v); #1; chk_out("mw_c2", OutStall, MaskAll); step("mw_c2", OutStall);
      v.req = 1'b1; v.ack = 1'b1;
      apply(v); #1; chk_out("mw_ack", OutRun, MaskAll); step("mw_ack", OutRun);
      chk16("mw_stall_delta", stall_cnt - base, 16'd3);
      v = '0;
      apply(v); #1; chk_out("mw_after", OutRun, MaskAll); step("mw_after", OutRun);

      // Memory wait with mispredict (and a load-use) held throughout.
      base = exp_flush;
      v = mk(5'd6, 5'd0, 1, 0, 5'd6, 1, 1, 1, 1, 0, OutStall, MaskAll);
      apply(v); #1; chk_out("mwm_c0", OutStall, MaskAll); step("mwm_c0", OutStall);
      apply(v); #1; chk_out("mwm_c1", OutStall, MaskAll); step("mwm_c1", OutStall);
      apply(v); #1; chk_out("mwm_c2", OutStall, MaskAll); step("mwm_c2", OutStall);
      v.ack = 1'b1;
      apply(v); #1; chk_out("mwm_ack", OutMis, MaskAll); step("mwm_ack", OutMis);
      chk16("mwm_flush_delta", flush_cnt - base, 16'd1);
      v = '0;
      apply(v); #1; chk_out("mwm_after", OutRun, MaskAll); step("mwm_after", OutRun);

      // Saturation: a very long memory wait.
      v = '0;
      v.req = 1'b1;
      apply(v);
      for (int n = 0; n < 65540; n++) begin
         @(posedge clk);
         if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      end
      #1;
      chk16("sat_stall_cnt", stall_cnt, 16'hFFFF);
      @(negedge clk);
      step("sat_hold", OutStall);

      // Reset asserted mid-MEM_WAIT, away from any clock edge.
      #2;
      rst_ni = 1'b0;
      #1;
      exp_stall = 16'd0;
      exp_flush = 16'd0;
      chk16("rst_mw_stall_cnt", stall_cnt, 16'd0);
      chk16("rst_mw_flush_cnt", flush_cnt, 16'd0);
      chk_out("rst_mw_outputs", OutStall, MaskAll);
      @(negedge clk);
      v = '0;
      apply(v);
      rst_ni = 1'b1;
      #1;
      chk_out("rst_mw_release", OutRun, MaskAll);
      step("rst_mw_release", OutRun);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
